// File: rtl/snd_link_pkg.sv
// ============================================================================
// snd_link_pkg : link word format constants shared by sender and receiver
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package snd_link_pkg;

    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] K_TRIG = 8'h1C;

    localparam int HDR_FLAG    = 15;
    localparam int HDR_CHAN_HI = 14;
    localparam int HDR_CHAN_LO = 9;
    localparam int HDR_LEN_HI  = 8;
    localparam int HDR_LEN_LO  = 0;

    localparam int ERR_TRUNC  = 0;
    localparam int ERR_ORPHAN = 1;
    localparam int ERR_CHAN   = 2;
    localparam int ERR_TMO    = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BLOCK = 1'b1
    } rcv_state_e;

    function automatic logic [5:0] hdr_chan(input logic [15:0] w);
        return w[HDR_CHAN_HI:HDR_CHAN_LO];
    endfunction

    function automatic logic [8:0] hdr_len(input logic [15:0] w);
        return w[HDR_LEN_HI:HDR_LEN_LO];
    endfunction

endpackage

`default_nettype wire

// File: rtl/snd_rcv_cls.sv
// ============================================================================
// snd_rcv_cls : combinational classifier for one received link word
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module snd_rcv_cls
    import snd_link_pkg::*;
(
    input  logic       kchar,
    input  logic       flag,
    input  logic [7:0] low_byte,
    output logic       is_hdr,
    output logic       is_data,
    output logic       is_trig,
    output logic       is_idle
);

    assign is_hdr  = ~kchar &  flag;
    assign is_data = ~kchar & ~flag;
    assign is_trig =  kchar & (low_byte == K_TRIG);
    assign is_idle =  kchar & (low_byte == K_IDLE);

endmodule

`default_nettype wire

// File: rtl/snd_rcv.sv
// ============================================================================
// snd_rcv : link receiver - block delineation, checking and trigger recovery
// Optional statistics counters enabled with `define SND_RCV_STAT_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module snd_rcv
    import snd_link_pkg::*;
#(
    parameter int NCHAN = 17,
    parameter int TMO   = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] datain,
    input  logic        kchar,
    output logic [15:0] dout,
    output logic [5:0]  dout_chan,
    output logic        dout_valid,
    output logic        dout_first,
    output logic        dout_last,
    output logic        dout_abort,
    output logic        trig,
    output logic [3:0]  err
`ifdef SND_RCV_STAT_EN
    ,
    output logic [31:0] blk_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [6:0] NCHAN_LIM = 7'(NCHAN);
    localparam logic [8:0] TMO_LIM   = 9'(TMO);

    logic w_is_hdr, w_is_data, w_is_trig, w_unused_idle;

    // Idle words carry nothing on the receive side; they only pace the link.
    snd_rcv_cls u_cls (
        .kchar    (kchar),
        .flag     (datain[HDR_FLAG]),
        .low_byte (datain[7:0]),
        .is_hdr   (w_is_hdr),
        .is_data  (w_is_data),
        .is_trig  (w_is_trig),
        .is_idle  (w_unused_idle)
    );

    rcv_state_e  state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [8:0]  tmo_q, tmo_d;
    logic [15:0] dout_q, dout_d;
    logic [5:0]  dout_chan_q, dout_chan_d;
    logic        valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic        abort_q, abort_d, trig_q, trig_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  w_evt;
    logic        w_chan_ok;
    logic [8:0]  w_tmo_inc;

    assign w_chan_ok = {1'b0, hdr_chan(datain)} < NCHAN_LIM;
    assign w_tmo_inc = tmo_q + 9'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        dout_d      = dout_q;
        dout_chan_d = dout_chan_q;
        valid_d     = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        abort_d     = 1'b0;
        trig_d      = w_is_trig;
        w_evt       = 4'b0000;

        if (state_q == ST_BLOCK) begin
            if (w_is_data) begin
                valid_d = 1'b1;
                dout_d  = datain;
                cnt_d   = cnt_q - 9'd1;
                tmo_d   = 9'd0;
                if (cnt_q == 9'd1) begin
                    last_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end else if (w_is_hdr) begin
                w_evt[ERR_TRUNC] = 1'b1;
                abort_d          = 1'b1;
                state_d          = ST_IDLE;
                tmo_d            = 9'd0;
            end else if (w_tmo_inc == TMO_LIM) begin
                w_evt[ERR_TMO] = 1'b1;
                abort_d        = 1'b1;
                state_d        = ST_IDLE;
                tmo_d          = 9'd0;
            end else begin
                tmo_d = w_tmo_inc;
            end
        end else if (w_is_data) begin
            w_evt[ERR_ORPHAN] = 1'b1;
        end

        // A header is handled identically whether or not it closed a truncated block.
        if (w_is_hdr) begin
            if (w_chan_ok) begin
                valid_d     = 1'b1;
                first_d     = 1'b1;
                dout_d      = datain;
                dout_chan_d = hdr_chan(datain);
                cnt_d       = hdr_len(datain);
                tmo_d       = 9'd0;
                if (hdr_len(datain) == 9'd0) begin
                    last_d = 1'b1;
                end else begin
                    state_d = ST_BLOCK;
                end
            end else begin
                w_evt[ERR_CHAN] = 1'b1;
            end
        end

        err_d = err_q | w_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 9'd0;
            tmo_q       <= 9'd0;
            dout_q      <= 16'd0;
            dout_chan_q <= 6'd0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            abort_q     <= 1'b0;
            trig_q      <= 1'b0;
            err_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            dout_q      <= dout_d;
            dout_chan_q <= dout_chan_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            abort_q     <= abort_d;
            trig_q      <= trig_d;
            err_q       <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_chan  = dout_chan_q;
    assign dout_valid = valid_q;
    assign dout_first = first_q;
    assign dout_last  = last_q;
    assign dout_abort = abort_q;
    assign trig       = trig_q;
    assign err        = err_q;

`ifdef SND_RCV_STAT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [2:0]  w_n_evt;
    logic [16:0] w_err_sum;

    // Two error events can land in one clock (truncation plus a bad channel).
    assign w_n_evt   = 3'(w_evt[0]) + 3'(w_evt[1]) + 3'(w_evt[2]) + 3'(w_evt[3]);
    assign w_err_sum = {1'b0, err_cnt_q} + 17'(w_n_evt);

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        err_cnt_d = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        if (last_d && (blk_cnt_q != 32'hFFFF_FFFF)) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt_q <= 32'd0;
            err_cnt_q <= 16'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_snd_rcv.sv
// ============================================================================
// tb_snd_rcv : directed bench for snd_rcv with a word-level reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snd_rcv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] datain = 16'h50BC;
    logic        kchar = 1'b1;
    logic [15:0] dout;
    logic [5:0]  dout_chan;
    logic        dout_valid, dout_first, dout_last, dout_abort, trig;
    logic [3:0]  err;
`ifdef SND_RCV_STAT_EN
    logic [31:0] blk_cnt;
    logic [15:0] err_cnt;
`endif

    snd_rcv dut (
        .clk        (clk),
        .reset      (reset),
        .datain     (datain),
        .kchar      (kchar),
        .dout       (dout),
        .dout_chan  (dout_chan),
        .dout_valid (dout_valid),
        .dout_first (dout_first),
        .dout_last  (dout_last),
        .dout_abort (dout_abort),
        .trig       (trig),
        .err        (err)
`ifdef SND_RCV_STAT_EN
        ,
        .blk_cnt    (blk_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decides the registered outputs from the word rules.
    bit          started = 1'b0;
    bit          in_blk = 1'b0;
    int          rem = 0, gap = 0, ch = 0, ln = 0, ev = 0;
    logic        e_valid = 1'b0, e_first = 1'b0, e_last = 1'b0, e_abort = 1'b0, e_trig = 1'b0;
    logic [3:0]  e_err = 4'd0;
    logic [15:0] e_dout = 16'd0;
    logic [5:0]  e_chan = 6'd0;
    int          e_blk = 0, e_errc = 0;

    always @(posedge clk) begin
        started = 1'b1;
        e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_abort = 1'b0; e_trig = 1'b0;
        ev = 0;
        if (reset) begin
            in_blk = 1'b0; rem = 0; gap = 0;
            e_err = 4'd0; e_dout = 16'd0; e_chan = 6'd0; e_blk = 0; e_errc = 0;
        end else begin
            if (kchar) begin
                if (datain[7:0] == 8'h1C) e_trig = 1'b1;
                if (in_blk) begin
                    gap = gap + 1;
                    if (gap >= 255) begin
                        e_err = e_err | 4'b1000; e_abort = 1'b1; ev++; in_blk = 1'b0;
                    end
                end
            end else if (datain[15]) begin
                if (in_blk) begin
                    e_err = e_err | 4'b0001; e_abort = 1'b1; ev++; in_blk = 1'b0;
                end
                ch = (int'(datain) >> 9) & 63;
                ln = int'(datain) & 511;
                if (ch < 17) begin
                    e_valid = 1'b1; e_first = 1'b1; e_dout = datain; e_chan = 6'(ch);
                    if (ln == 0) e_last = 1'b1;
                    else begin in_blk = 1'b1; rem = ln; gap = 0; end
                end else begin
                    e_err = e_err | 4'b0100; ev++;
                end
            end else begin
                if (in_blk) begin
                    e_valid = 1'b1; e_dout = datain; rem = rem - 1; gap = 0;
                    if (rem == 0) begin e_last = 1'b1; in_blk = 1'b0; end
                end else begin
                    e_err = e_err | 4'b0010; ev++;
                end
            end
            if (e_last) e_blk++;
            e_errc = e_errc + ev;
        end
    end

    int n_valid_seen = 0;

    always @(negedge clk) begin
        if (started) begin
            check("valid", dout_valid, e_valid);
            check("first", dout_first, e_first);
            check("last",  dout_last,  e_last);
            check("abort", dout_abort, e_abort);
            check("trig",  trig,       e_trig);
            check("err",   err,        e_err);
            if (e_valid) begin
                check("dout",      dout,      e_dout);
                check("dout_chan", dout_chan, e_chan);
            end
`ifdef SND_RCV_STAT_EN
            check("blk_cnt", blk_cnt, e_blk);
            check("err_cnt", err_cnt, e_errc);
`endif
            if (dout_valid === 1'b1) n_valid_seen++;
        end
    end

    task automatic send(input bit k, input logic [15:0] w);
        @(negedge clk);
        kchar  = k;
        datain = w;
    endtask

    // Returns just after the clock edge that registered the last sent word.
    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 16'h50BC);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        kchar  = 1'b1;
        datain = 16'h50BC;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int base;

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        peek();
        check("rst_valid", dout_valid, 1'b0);
        check("rst_err",   err,        4'd0);
        check("rst_dout",  dout,       16'd0);
        check("rst_abort", dout_abort, 1'b0);

        // Basic 4-word block on channel 3
        base = n_valid_seen;
        send(1'b0, 16'h8604); peek();
        check("t1_first", dout_first, 1'b1);
        check("t1_chan",  dout_chan,  6'd3);
        check("t1_hdr",   dout,       16'h8604);
        send(1'b0, 16'h0004); send(1'b0, 16'h0003); send(1'b0, 16'h0002);
        send(1'b0, 16'h0001); peek();
        check("t1_last",  dout_last,  1'b1);
        check("t1_ldata", dout,       16'h0001);
        send(1'b1, 16'h50BC); peek();
        check("t1_nvalid", n_valid_seen - base, 5);
        check("t1_err",    err,                 4'd0);

        // Trigger k-word inside a block
        send(1'b0, 16'h8604); send(1'b0, 16'h0004); send(1'b0, 16'h0003);
        send(1'b1, 16'h501C); peek();
        check("t2_trig",   trig,       1'b1);
        check("t2_tvalid", dout_valid, 1'b0);
        send(1'b0, 16'h0002); peek();
        check("t2_trig0",  trig,       1'b0);
        send(1'b0, 16'h0001); peek();
        check("t2_last",   dout_last,  1'b1);

        // Truncated block followed directly by a new header
        do_reset();
        send(1'b0, 16'h8C02); send(1'b0, 16'h0005);
        send(1'b0, 16'h8601); peek();
        check("t3_abort", dout_abort, 1'b1);
        check("t3_first", dout_first, 1'b1);
        check("t3_chan",  dout_chan,  6'd3);
        check("t3_err",   err,        4'b0001);
        send(1'b0, 16'h0007); peek();
        check("t3_last",  dout_last,  1'b1);

        // Illegal channel 17, then an orphan data word
        do_reset();
        send(1'b0, 16'hA201); peek();
        check("t4_hvalid", dout_valid, 1'b0);
        check("t4_err1",   err,        4'b0100);
        send(1'b0, 16'h0001); peek();
        check("t4_dvalid", dout_valid, 1'b0);
        check("t4_err2",   err,        4'b0110);

        // Timeout after 255 idle clocks inside a block
        do_reset();
        send(1'b0, 16'h8602); send(1'b0, 16'h0001);
        idle_n(254); peek();
        check("t5_noabort", dout_abort, 1'b0);
        idle_n(1); peek();
        check("t5_abort",   dout_abort, 1'b1);
        check("t5_err",     err,        4'b1000);
        send(1'b0, 16'h0002); peek();
        check("t5_orphan",  err,        4'b1010);

        // Zero-length block
        do_reset();
        send(1'b0, 16'h8600); peek();
        check("t6_first", dout_first, 1'b1);
        check("t6_last",  dout_last,  1'b1);
`ifdef SND_RCV_STAT_EN
        check("t6_blk",   blk_cnt,    32'd1);
`endif

        // Maximum length 511 on channel 0
        send(1'b0, 16'h81FF);
        for (int i = 1; i < 511; i++) send(1'b0, 16'(i));
        peek();
        check("t7_notlast", dout_last, 1'b0);
        send(1'b0, 16'h7FFF); peek();
        check("t7_last",  dout_last, 1'b1);
        check("t7_err",   err,       4'd0);

        // Reset in the middle of a block is silent
        send(1'b0, 16'h8605); send(1'b0, 16'h0001);
        do_reset(); peek();
        check("t8_abort", dout_abort, 1'b0);
        send(1'b0, 16'h0002); peek();
        check("t8_err",   err,        4'b0010);

        idle_n(3);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
